// File: rtl/dose_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dose_alarm_scheduler
// Description : Medication reminder scheduler. Arms a repeating countdown for
//               the selected medicine, sounds an alarm when it expires, and
//               tallies acknowledged and missed doses.
// Ports       : Clk, Rst (async, active-high), Enable (freeze when low),
//               Tick (1-cycle time base), ArmButton / AckButton (levels),
//               SelectedAddress[5:0], SelectedData[3:0], IntervalIn[7:0] ->
//               Alarm, ActiveMed[3:0], ActiveAddress[5:0], Remaining[7:0],
//               DoseCount[3:0], MissedCount[3:0], State[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module dose_alarm_scheduler #(
    parameter logic [7:0] ALARM_TIMEOUT = 8'd30
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enable,
    input  logic       Tick,
    input  logic       ArmButton,
    input  logic       AckButton,
    input  logic [5:0] SelectedAddress,
    input  logic [3:0] SelectedData,
    input  logic [7:0] IntervalIn,
    output logic       Alarm,
    output logic [3:0] ActiveMed,
    output logic [5:0] ActiveAddress,
    output logic [7:0] Remaining,
    output logic [3:0] DoseCount,
    output logic [3:0] MissedCount,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        ALARM   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam logic [3:0] c_STOP_WORD = 4'b1111;
    localparam logic [3:0] c_SAT_MAX   = 4'hF;

    state_t     r_state,    w_state_nx;
    logic       r_arm_d,    r_ack_d;
    logic [7:0] r_timer,    w_timer_nx;
    logic [7:0] r_interval, w_interval_nx;
    logic [3:0] r_med,      w_med_nx;
    logic [5:0] r_addr,     w_addr_nx;
    logic [7:0] r_rem,      w_rem_nx;
    logic [3:0] r_dose,     w_dose_nx;
    logic [3:0] r_miss,     w_miss_nx;

    logic w_arm_pulse;
    logic w_ack_pulse;
    logic w_arm_valid;

    // Edge detectors compare against copies that only advance while enabled,
    // so a level that rose during a freeze is still seen once on resume.
    assign w_arm_pulse = ArmButton & ~r_arm_d;
    assign w_ack_pulse = AckButton & ~r_ack_d;
    assign w_arm_valid = w_arm_pulse && (SelectedData != c_STOP_WORD) && (IntervalIn != 8'd0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_arm_d    <= 1'b0;
            r_ack_d    <= 1'b0;
            r_timer    <= 8'd0;
            r_interval <= 8'd0;
            r_med      <= 4'd0;
            r_addr     <= 6'd0;
            r_rem      <= 8'd0;
            r_dose     <= 4'd0;
            r_miss     <= 4'd0;
        end else if (Enable) begin
            r_state    <= w_state_nx;
            r_arm_d    <= ArmButton;
            r_ack_d    <= AckButton;
            r_timer    <= w_timer_nx;
            r_interval <= w_interval_nx;
            r_med      <= w_med_nx;
            r_addr     <= w_addr_nx;
            r_rem      <= w_rem_nx;
            r_dose     <= w_dose_nx;
            r_miss     <= w_miss_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_interval_nx = r_interval;
        w_med_nx      = r_med;
        w_addr_nx     = r_addr;
        w_rem_nx      = r_rem;
        w_dose_nx     = r_dose;
        w_miss_nx     = r_miss;

        case (r_state)
            IDLE: begin
                if (w_arm_valid) begin
                    w_med_nx      = SelectedData;
                    w_addr_nx     = SelectedAddress;
                    w_interval_nx = IntervalIn;
                    w_rem_nx      = IntervalIn;
                    w_state_nx    = COUNT;
                end
            end

            COUNT: begin
                // A re-arm outranks a Tick landing in the same cycle.
                if (w_arm_valid) begin
                    w_med_nx      = SelectedData;
                    w_addr_nx     = SelectedAddress;
                    w_interval_nx = IntervalIn;
                    w_rem_nx      = IntervalIn;
                end else if (Tick) begin
                    if (r_rem <= 8'd1) begin
                        w_rem_nx   = 8'd0;
                        w_timer_nx = 8'd0;
                        w_state_nx = ALARM;
                    end else begin
                        w_rem_nx = r_rem - 8'd1;
                    end
                end
            end

            ALARM: begin
                // The user's acknowledgement wins over a simultaneous timeout.
                if (w_ack_pulse) begin
                    w_dose_nx  = (r_dose == c_SAT_MAX) ? r_dose : r_dose + 4'd1;
                    w_rem_nx   = r_interval;
                    w_state_nx = COUNT;
                end else if (Tick) begin
                    if (r_timer == ALARM_TIMEOUT - 8'd1) begin
                        w_miss_nx  = (r_miss == c_SAT_MAX) ? r_miss : r_miss + 4'd1;
                        w_rem_nx   = r_interval;
                        w_state_nx = COUNT;
                    end else begin
                        w_timer_nx = r_timer + 8'd1;
                    end
                end
            end

            default: begin
                // Unreachable encoding: drop back to a clean idle.
                w_state_nx    = IDLE;
                w_timer_nx    = 8'd0;
                w_interval_nx = 8'd0;
                w_med_nx      = 4'd0;
                w_addr_nx     = 6'd0;
                w_rem_nx      = 8'd0;
                w_dose_nx     = 4'd0;
                w_miss_nx     = 4'd0;
            end
        endcase
    end

    assign Alarm         = (r_state == ALARM);
    assign State         = r_state;
    assign ActiveMed     = r_med;
    assign ActiveAddress = r_addr;
    assign Remaining     = r_rem;
    assign DoseCount     = r_dose;
    assign MissedCount   = r_miss;

endmodule
`default_nettype wire

// File: doc/dose_alarm_scheduler.md
DOSE_ALARM_SCHEDULER -- requirements
Module: dose_alarm_scheduler

Interface
REQ-001 SHALL have parameter ALARM_TIMEOUT, default 8'd30: ticks the alarm may sound before the dose counts as missed.
REQ-002 SHALL have port Clk, input, 1: sole clock; all state changes on posedge.
REQ-003 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port Enable, input, 1: high = run; low = freeze all state, ignore buttons and Tick.
REQ-005 SHALL have port Tick, input, 1: one-Clk-wide time-base pulse, 1 Hz nominal.
REQ-006 SHALL have port ArmButton, input, 1: level, active-high; arms a schedule for the current selection.
REQ-007 SHALL have port AckButton, input, 1: level, active-high; user confirms dose taken.
REQ-008 SHALL have port SelectedAddress, input, 6: ROM address of the selected medicine from the browse stage.
REQ-009 SHALL have port SelectedData, input, 4: selected medicine ID; 4'b1111 = stop word, invalid.
REQ-010 SHALL have port IntervalIn, input, 8: dose interval in ticks; 0 = invalid.
REQ-011 SHALL have port Alarm, output, 1: high while in ALARM.
REQ-012 SHALL have port ActiveMed, output, 4: latched medicine ID.
REQ-013 SHALL have port ActiveAddress, output, 6: latched ROM address.
REQ-014 SHALL have port Remaining, output, 8: ticks left until the next alarm.
REQ-015 SHALL have port DoseCount, output, 4: acknowledged doses, saturating.
REQ-016 SHALL have port MissedCount, output, 4: timed-out doses, saturating.
REQ-017 SHALL have port State, output, 2: IDLE=0, COUNT=1, ALARM=2.

Function
REQ-018 SHALL derive arm and ack pulses by rising-edge detection, each against a one-cycle-delayed copy; a held button SHALL produce one pulse only.
REQ-019 SHALL, with Enable low, hold every register, including the edge-detect copies; an edge SHALL be detected on the first enabled cycle if the level rose while disabled.
REQ-020 SHALL, in IDLE on an arm pulse with SelectedData != 4'b1111 and IntervalIn != 0, latch ActiveMed, ActiveAddress and an internal interval copy, set Remaining = IntervalIn, and enter COUNT on the next edge.
REQ-021 SHALL ignore an arm pulse whose selection or interval is invalid; state and outputs SHALL remain unchanged.
REQ-022 SHALL, in COUNT on Tick, decrement Remaining; when Tick arrives with Remaining == 1, it SHALL set Remaining to 0, clear the alarm timer and enter ALARM.
REQ-023 SHALL, in COUNT on a valid arm pulse, re-latch the selection and reload Remaining without changing either counter; an arm pulse and Tick in the same cycle SHALL resolve in favour of the arm pulse.
REQ-024 SHALL, in ALARM, drive Alarm = 1 combinationally from State and increment the 8-bit alarm timer on each Tick.
REQ-025 SHALL, in ALARM on an ack pulse, increment DoseCount (saturating at 15), reload Remaining from the interval copy and enter COUNT.
REQ-026 SHALL, in ALARM when Tick arrives with alarm timer == ALARM_TIMEOUT-1, increment MissedCount (saturating at 15), reload Remaining and enter COUNT.
REQ-027 SHALL give an ack pulse priority over a timeout or Tick occurring in the same cycle.
REQ-028 SHALL ignore arm pulses in ALARM, and ack pulses in IDLE and COUNT.
REQ-029 SHALL treat State value 3 as illegal and recover to IDLE with all outputs cleared on the next edge.

Reset
REQ-030 SHALL, while Rst is high and regardless of Clk, force State=IDLE, Alarm=0, ActiveMed=0, ActiveAddress=0, Remaining=0, DoseCount=0, MissedCount=0, and clear the alarm timer, interval copy and edge-detect copies.
REQ-031 SHALL, on reset mid-COUNT or mid-ALARM, abandon the schedule; the first edge after release SHALL act only on new edges (a button held through reset yields one pulse).

Verification
REQ-032 SHALL verify: arm with Med=5, Addr=3, Interval=3, then 3 Ticks -> State=ALARM, Alarm=1, Remaining=0, ActiveMed=5, ActiveAddress=3.
REQ-033 SHALL verify: in ALARM, Ack then 3 further Ticks -> DoseCount=1, State returns to ALARM with Remaining 3,2,1,0 along the way.
REQ-034 SHALL verify: ALARM_TIMEOUT=4 with no Ack for 4 Ticks -> MissedCount=1, State=COUNT, Remaining=Interval.
REQ-035 SHALL verify: arm with SelectedData=4'b1111 or IntervalIn=0 -> State stays IDLE and all outputs stay 0.
REQ-036 SHALL verify: Ack coinciding with the timeout Tick -> DoseCount increments and MissedCount does not; 16 acks -> DoseCount stays at 15.
REQ-037 SHALL verify: Rst asserted between Clk edges mid-COUNT -> outputs clear immediately; Enable low for 10 Ticks -> Remaining frozen.
